// File: rtl/rs_pkg.sv
// ---------------------------------------------------------------------------
// rs_pkg
// Shared RS(544,514) definitions over GF(2^10), field polynomial x^10+x^3+1.
// Used by the transmit encoder and by the receive syndrome unit.
// Contents:
//   N, K, NSYM, M      code geometry
//   FIELD_POLY         primitive polynomial (bit 10 included)
//   gf_sym_t           one 10-bit field symbol
//   gen_tab_t          30 packed generator coefficients, index j = coeff of x^j
//   gf_mul             general GF(2^10) multiply
//   gf_alpha_pow       alpha power lookup (alpha^e)
//   RS_GEN             coefficients g0..g29 of prod_{i=0..29}(x + alpha^i)
// ---------------------------------------------------------------------------
package rs_pkg;

  localparam int N    = 544;
  localparam int K    = 514;
  localparam int NSYM = 30;
  localparam int M    = 10;

  localparam logic [M:0] FIELD_POLY = 11'h409;

  typedef logic [M-1:0]             gf_sym_t;
  typedef logic [NSYM-1:0][M-1:0]   gen_tab_t;

  localparam gf_sym_t ALPHA = 10'h002;

  // Shift-and-add multiply; the running multiplicand is reduced every step.
  function automatic gf_sym_t gf_mul(input gf_sym_t a, input gf_sym_t b);
    gf_sym_t acc;
    gf_sym_t sh;
    acc = 10'h000;
    sh  = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) acc = acc ^ sh;
      else      acc = acc;
      if (sh[M-1]) sh = {sh[M-2:0], 1'b0} ^ FIELD_POLY[M-1:0];
      else         sh = {sh[M-2:0], 1'b0};
    end
    return acc;
  endfunction

  // Alpha power table entry alpha^e; the multiplicative group has order 1023.
  function automatic gf_sym_t gf_alpha_pow(input int unsigned e);
    gf_sym_t r;
    r = 10'h001;
    for (int unsigned i = 0; i < (e % 32'd1023); i++) r = gf_mul(r, ALPHA);
    return r;
  endfunction

  // Expand prod (x + alpha^i) one root at a time; the monic x^30 term is dropped.
  function automatic gen_tab_t calc_gen();
    logic [NSYM:0][M-1:0] g;
    gf_sym_t              root;
    g    = '0;
    g[0] = 10'h001;
    root = 10'h001;
    for (int i = 0; i < NSYM; i++) begin
      for (int k = NSYM; k >= 1; k--) g[k] = g[k-1] ^ gf_mul(g[k], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, ALPHA);
    end
    return g[NSYM-1:0];
  endfunction

  localparam gen_tab_t RS_GEN = calc_gen();

endpackage

// File: rtl/rs_enc_kp4_if.sv
// ---------------------------------------------------------------------------
// rs_enc_kp4_if
// Symbol stream bundle around the RS encoder.
//   sop, valid_in, data_in       message symbols from the TX framer
//   ready_in                     encoder back-pressure
//   valid_out, sop_out, eop_out,
//   data_out                     codeword symbols to the distributor
//   err_out                      framing error pulse
// Modports: master = upstream/testbench side, slave = encoder side.
// ---------------------------------------------------------------------------
interface rs_enc_kp4_if import rs_pkg::*; ;
  logic    sop;
  logic    valid_in;
  gf_sym_t data_in;
  logic    ready_in;
  logic    valid_out;
  logic    sop_out;
  logic    eop_out;
  gf_sym_t data_out;
  logic    err_out;

  modport master (
    output sop, valid_in, data_in,
    input  ready_in, valid_out, sop_out, eop_out, data_out, err_out
  );

  modport slave (
    input  sop, valid_in, data_in,
    output ready_in, valid_out, sop_out, eop_out, data_out, err_out
  );
endinterface

// File: rtl/rs_gf_mul_const.sv
// ---------------------------------------------------------------------------
// rs_gf_mul_const
// Combinational GF(2^10) multiply by the constant COEF; with a constant
// operand synthesis folds gf_mul into a small XOR network.
//   a_i  in   M   variable operand
//   p_o  out  M   a_i * COEF
// ---------------------------------------------------------------------------
module rs_gf_mul_const import rs_pkg::*; #(
  parameter gf_sym_t COEF = 10'h001
) (
  input  gf_sym_t a_i,
  output gf_sym_t p_o
);
  assign p_o = gf_mul(a_i, COEF);
endmodule

// File: rtl/rs_enc_kp4.sv
// ---------------------------------------------------------------------------
// rs_enc_kp4
// Systematic RS(544,514) encoder: 514 message symbols pass through with one
// cycle of latency, then the 30 parity symbols follow with no bubble.
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   bus     slave modport of rs_enc_kp4_if (handshake and symbol streams)
// ---------------------------------------------------------------------------
module rs_enc_kp4 import rs_pkg::*; (
  input  logic          clk,
  input  logic          rst_n,
  rs_enc_kp4_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2} state_e;

  localparam logic [9:0] CNT_DATA_LAST = 10'(K - 1);
  localparam logic [9:0] CNT_PAR_LAST  = 10'(NSYM - 1);

  state_e   state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  gen_tab_t par_q, par_d;
  gen_tab_t base_s, prod_s, lfsr_s;
  gf_sym_t  fb_s;
  logic     ready_s, accept_s;
  logic     valid_q, valid_d, sop_q, sop_d, eop_q, eop_d, err_q, err_d;
  gf_sym_t  data_q, data_d;

  assign ready_s  = (state_q != PARITY);
  assign accept_s = bus.valid_in & ready_s;

  // A starting codeword sees an empty remainder register.
  assign base_s = bus.sop ? '0 : par_q;
  assign fb_s   = bus.data_in ^ base_s[NSYM-1];

  for (genvar j = 0; j < NSYM; j++) begin : g_mul
    rs_gf_mul_const #(.COEF(RS_GEN[j])) u_mul (.a_i(fb_s), .p_o(prod_s[j]));
  end

  // Remainder register update for one accepted message symbol.
  always_comb begin
    lfsr_s[0] = prod_s[0];
    for (int j = 1; j < NSYM; j++) lfsr_s[j] = base_s[j-1] ^ prod_s[j];
  end

  // Next state, counter, remainder and output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    valid_d = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    err_d   = 1'b0;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (accept_s && bus.sop) begin
          state_d = DATA;
          cnt_d   = 10'd1;
          par_d   = lfsr_s;
          valid_d = 1'b1;
          sop_d   = 1'b1;
          data_d  = bus.data_in;
        end else if (accept_s) begin
          err_d   = 1'b1;   // orphan symbol is dropped
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (accept_s) begin
          par_d   = lfsr_s;
          valid_d = 1'b1;
          sop_d   = bus.sop;
          data_d  = bus.data_in;
          if (bus.sop) begin
            err_d = 1'b1;   // restart: this symbol is message symbol 0
            cnt_d = 10'd1;
          end else if (cnt_q == CNT_DATA_LAST) begin
            state_d = PARITY;
            cnt_d   = 10'd0;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      PARITY: begin
        valid_d = 1'b1;
        data_d  = par_q[NSYM-1];
        par_d   = {par_q[NSYM-2:0], 10'h000};
        if (cnt_q == CNT_PAR_LAST) begin
          eop_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = 10'd0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 10'd0;
        par_d   = '0;
      end
    endcase
  end

  // State, remainder and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 10'd0;
      par_q   <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= 10'h000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign bus.ready_in  = ready_s;
  assign bus.valid_out = valid_q;
  assign bus.sop_out   = sop_q;
  assign bus.eop_out   = eop_q;
  assign bus.err_out   = err_q;
  assign bus.data_out  = data_q;

endmodule
